// File: rtl/sm83_bus_target.sv
// sm83_bus_target: data-bus responder for the SM83 core.
// Services CPU read/write M-cycles: high RAM (FF80-FFFE) and the IE register
// (FFFF) are handled internally; every other address goes out over a level
// request/acknowledge port. Read data is presented to the CPU in T4.
module sm83_bus_target #(
    parameter logic [7:0] EXT_TIMEOUT_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_wdata,
    input  logic        dma_active,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_adr,
    output logic [7:0]  ext_wdata,
    input  logic        ext_ack,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  ie,
    output logic        bus_timeout,
    output logic        bus_conflict,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_INT, S_EXT_WAIT, S_EXT_DONE, S_BLOCKED, S_FINISH
    } state_t;

    typedef enum logic [1:0] { C_HRAM, C_IE, C_EXT } cls_t;

    state_t     state, next_state, entry_state;
    cls_t       cpu_cls, req_cls;
    logic [6:0] req_idx;
    logic [7:0] req_wdata;
    logic       req_we;
    logic       req_tmo;
    logic       latch;
    logic       ack_take;
    logic       tmo_hit;

    logic [7:0] hram [127];

    // Decode target class straight from the CPU address latch.
    always_comb begin
        cpu_cls = C_EXT;
        if (cpu_adr == 16'hFFFF)
            cpu_cls = C_IE;
        else if (cpu_adr[15:7] == 9'h1FF)
            cpu_cls = C_HRAM;
    end

    // A request is only accepted in T4 while idle or finishing, so a new
    // M-cycle can chain directly behind the one completing.
    assign latch    = t4 && (cpu_rd || cpu_wr) && (state == S_IDLE || state == S_FINISH);
    // Only the first acknowledge inside T1..T3 counts; leaving EXT_WAIT masks the rest.
    assign ack_take = (state == S_EXT_WAIT) && ext_ack && (t1 || t2 || t3);
    assign tmo_hit  = (state == S_EXT_WAIT) && t3 && !ack_take;

    assign entry_state = (cpu_cls != C_EXT) ? S_INT :
                         dma_active         ? S_BLOCKED : S_EXT_WAIT;

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state and T4 status outputs.
    always_comb begin
        next_state  = state;
        rdata_valid = 1'b0;
        bus_timeout = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (latch) next_state = entry_state;
            end
            S_INT, S_EXT_DONE, S_BLOCKED: begin
                if (t3) next_state = S_FINISH;
            end
            S_EXT_WAIT: begin
                // An acknowledge on the T3 edge completes straight into FINISH.
                if (ack_take)
                    next_state = t3 ? S_FINISH : S_EXT_DONE;
                else if (t3)
                    next_state = S_FINISH;
            end
            S_FINISH: begin
                rdata_valid = !req_we;
                bus_timeout = req_tmo;
                if (t4) next_state = latch ? entry_state : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Request latch, external port, IE register and read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_cls      <= C_HRAM;
            req_idx      <= '0;
            req_wdata    <= '0;
            req_we       <= 1'b0;
            req_tmo      <= 1'b0;
            bus_conflict <= 1'b0;
            ext_req      <= 1'b0;
            ext_we       <= 1'b0;
            ext_adr      <= '0;
            ext_wdata    <= '0;
            ie           <= 8'h00;
            rdata        <= 8'hFF;
        end else begin
            bus_conflict <= latch && cpu_rd && cpu_wr;

            if (latch) begin
                req_cls   <= cpu_cls;
                req_idx   <= cpu_adr[6:0];
                req_wdata <= cpu_wdata;
                req_we    <= cpu_wr;
                req_tmo   <= 1'b0;
                if (cpu_cls == C_EXT && !dma_active) begin
                    ext_req   <= 1'b1;
                    ext_we    <= cpu_wr;
                    ext_adr   <= cpu_adr;
                    ext_wdata <= cpu_wdata;
                end
            end

            if (ack_take) begin
                ext_req <= 1'b0;
                if (!req_we) rdata <= ext_rdata;
            end

            if (tmo_hit) begin
                ext_req <= 1'b0;
                req_tmo <= 1'b1;
                if (!req_we) rdata <= EXT_TIMEOUT_FILL;
            end

            if (state == S_INT && t2 && req_we && req_cls == C_IE)
                ie <= req_wdata;

            if (state == S_INT && t3 && !req_we)
                rdata <= (req_cls == C_IE) ? ie : hram[req_idx];

            if (state == S_BLOCKED && t3 && !req_we)
                rdata <= EXT_TIMEOUT_FILL;
        end
    end

    // High RAM write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_INT && t2 && req_we && req_cls == C_HRAM)
            hram[req_idx] <= req_wdata;
    end

endmodule
